// File: rtl/miller_rabin_prime_test.sv
// rtl/miller_rabin_prime_test.sv - sequential Miller-Rabin primality tester
// Bases run 2,3,4,... wrapping in [2, n-2]; mulmod is LSB-first shift-add, one multiplier bit per cycle.
module miller_rabin_prime_test #(
  parameter int WORDSIZE = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORDSIZE-1:0]   start_number,
  input  logic [2*WORDSIZE-1:0] accuracy,
  output logic                  prime,
  output logic                  finish
);

  localparam int W  = WORDSIZE;
  localparam int EW = $clog2(WORDSIZE);

  typedef enum logic [3:0] {
    START, TRIVIAL, DECOMP, PICK_A, EXP, CHECK, SQLOOP, NEXT, DONE
  } state_t;

  state_t state, next_state;

  logic [W-1:0]   n, d, a, x, n_minus1;
  logic [2*W-1:0] k, r;
  logic [EW-1:0]  s, j, e_idx;
  logic           exp_mul;

  logic           mm_busy;
  logic [W-1:0]   mm_acc, mm_m, mm_y;
  logic [W:0]     mm_sum, mm_dbl;
  logic [W-1:0]   mm_acc_nx, mm_m_nx;
  logic           mm_done, exp_bit, exp_finish, sq_hit, sq_fail;
  logic           mm_launch, verdict;

  assign n_minus1 = n - 1'b1;

  // acc < n and m < n, so one conditional subtraction keeps each below n
  assign mm_sum    = {1'b0, mm_acc} + {1'b0, mm_m};
  assign mm_dbl    = {mm_m, 1'b0};
  assign mm_acc_nx = (mm_sum >= {1'b0, n}) ? (mm_sum[W-1:0] - n) : mm_sum[W-1:0];
  assign mm_m_nx   = (mm_dbl >= {1'b0, n}) ? (mm_dbl[W-1:0] - n) : mm_dbl[W-1:0];
  assign mm_done   = mm_busy && (mm_y == '0);

  assign exp_bit    = d[e_idx];
  assign exp_finish = (state == EXP) && mm_done && (exp_mul || !exp_bit) && (e_idx == '0);
  assign sq_hit     = (state == SQLOOP) && mm_done && (mm_acc == n_minus1);
  assign sq_fail    = (state == SQLOOP) && !mm_busy && (j >= s);

  always_ff @(posedge clk) begin
    if (reset) state <= START;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      START:   next_state = TRIVIAL;
      TRIVIAL: begin
        if (n < W'(4) || !n[0]) next_state = DONE;
        else                    next_state = DECOMP;
      end
      DECOMP:  if (d[0]) next_state = PICK_A;
      PICK_A:  next_state = EXP;
      EXP:     if (exp_finish) next_state = CHECK;
      CHECK:   next_state = (x == W'(1) || x == n_minus1) ? NEXT : SQLOOP;
      SQLOOP: begin
        if (sq_fail)     next_state = DONE;
        else if (sq_hit) next_state = NEXT;
      end
      NEXT:    next_state = ((r + 1'b1) == k) ? DONE : PICK_A;
      DONE:    next_state = DONE;
      default: next_state = START;
    endcase
  end

  always_comb begin
    verdict   = 1'b0;
    mm_launch = 1'b0;
    case (state)
      TRIVIAL: verdict = (n == W'(2)) || (n == W'(3));
      NEXT:    verdict = 1'b1;
      EXP:     mm_launch = !mm_busy;
      SQLOOP:  mm_launch = !mm_busy && (j < s);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n       <= start_number;
      k       <= (accuracy == '0) ? (2*W)'(1) : accuracy;
      finish  <= 1'b0;
      prime   <= 1'b0;
      mm_busy <= 1'b0;
    end else begin
      if (next_state == DONE && state != DONE) begin
        finish <= 1'b1;
        prime  <= verdict;
      end
      if (mm_launch) begin
        mm_acc  <= '0;
        mm_m    <= x;
        mm_y    <= (state == EXP && exp_mul) ? a : x;
        mm_busy <= 1'b1;
      end else if (mm_busy && !mm_done) begin
        if (mm_y[0]) mm_acc <= mm_acc_nx;
        mm_m <= mm_m_nx;
        mm_y <= mm_y >> 1;
      end else if (mm_done) begin
        x       <= mm_acc;
        mm_busy <= 1'b0;
      end
      case (state)
        TRIVIAL: begin
          d <= n_minus1;
          s <= '0;
        end
        DECOMP: begin
          if (!d[0]) begin
            d <= d >> 1;
            s <= s + 1'b1;
          end else begin
            r <= '0;
            a <= W'(2);
          end
        end
        PICK_A: begin
          x       <= W'(1);
          e_idx   <= EW'(W - 1);
          exp_mul <= 1'b0;
        end
        EXP: begin
          // each exponent bit: square, then multiply by a if the bit is set
          if (mm_done) begin
            if (!exp_mul && exp_bit) begin
              exp_mul <= 1'b1;
            end else begin
              exp_mul <= 1'b0;
              e_idx   <= e_idx - 1'b1;
            end
          end
        end
        CHECK:  j <= EW'(1);
        SQLOOP: if (mm_done) j <= j + 1'b1;
        NEXT: begin
          r <= r + 1'b1;
          a <= ((a + 1'b1) == n_minus1) ? W'(2) : (a + 1'b1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miller_rabin_prime_test.sv
// tb/tb_miller_rabin_prime_test.sv - directed and model-checked bench for miller_rabin_prime_test
module tb_miller_rabin_prime_test;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] start_number;
  logic [255:0] accuracy;
  logic         prime;
  logic         finish;

  int checks = 0;
  int errors = 0;

  miller_rabin_prime_test #(.WORDSIZE(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_number (start_number),
    .accuracy     (accuracy),
    .prime        (prime),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [127:0] num, input logic [255:0] acc, input int limit,
                        output int cycles, output logic got);
    @(negedge clk);
    reset = 1'b1;
    start_number = num;
    accuracy = acc;
    @(negedge clk);
    reset = 1'b0;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < limit) begin
      @(negedge clk);
      cycles++;
      got = finish;
    end
  endtask

  function automatic longint unsigned mulmod(longint unsigned p, longint unsigned q, longint unsigned m);
    return (p * q) % m;
  endfunction

  function automatic longint unsigned powmod(longint unsigned b, longint unsigned e, longint unsigned m);
    longint unsigned res = 1;
    longint unsigned bb = b % m;
    while (e != 0) begin
      if (e[0]) res = mulmod(res, bb, m);
      bb = mulmod(bb, bb, m);
      e = e >> 1;
    end
    return res;
  endfunction

  // Strong-probable-prime test with the same base sequence as the hardware
  function automatic bit mr_model(longint unsigned n, int k);
    longint unsigned dd, a, xx;
    int ss;
    bit pass;
    if (n < 2) return 1'b0;
    if (n == 2 || n == 3) return 1'b1;
    if (!n[0]) return 1'b0;
    dd = n - 1;
    ss = 0;
    while (!dd[0]) begin
      dd = dd >> 1;
      ss++;
    end
    a = 2;
    for (int r = 0; r < k; r++) begin
      xx = powmod(a, dd, n);
      pass = (xx == 1) || (xx == n - 1);
      for (int jj = 1; jj < ss && !pass; jj++) begin
        xx = mulmod(xx, xx, n);
        if (xx == n - 1) pass = 1'b1;
      end
      if (!pass) return 1'b0;
      a = (a + 1 == n - 1) ? 2 : a + 1;
    end
    return 1'b1;
  endfunction

  initial begin
    int           cyc;
    logic         got;
    logic [127:0] m127;
    logic [127:0] num;
    logic [15:0]  w [8];
    int           trivial_n [5];
    bit           trivial_p [5];
    int           lim;

    m127 = (128'd1 << 127) - 128'd1;
    trivial_n = '{0, 1, 4, 100, 2};
    trivial_p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    start_number = '0;
    accuracy = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_finish", 64'(finish), 64'd0);
    check("reset_prime", 64'(prime), 64'd0);

    do_run(128'd3, 256'd5, 10, cyc, got);
    check("n3_finish", 64'(got), 64'd1);
    check("n3_latency", 64'(cyc <= 3), 64'd1);
    check("n3_prime", 64'(prime), 64'd1);
    for (int i = 0; i < 20; i++) begin
      start_number = 128'($urandom);
      accuracy = 256'($urandom);
      @(negedge clk);
      check("n3_hold", 64'({finish, prime}), 64'd3);
    end

    for (int i = 0; i < 5; i++) begin
      do_run(128'(trivial_n[i]), 256'd5, 10, cyc, got);
      check($sformatf("triv%0d_finish", trivial_n[i]), 64'(got), 64'd1);
      check($sformatf("triv%0d_latency", trivial_n[i]), 64'(cyc <= 3), 64'd1);
      check($sformatf("triv%0d_prime", trivial_n[i]), 64'(prime), 64'(trivial_p[i]));
    end

    do_run(128'd561, 256'd1, 20000, cyc, got);
    check("n561_finish", 64'(got), 64'd1);
    check("n561_prime", 64'(prime), 64'd0);

    do_run(128'd9, 256'd5, 20000, cyc, got);
    check("n9_finish", 64'(got), 64'd1);
    check("n9_prime", 64'(prime), 64'd0);

    do_run(128'd65537, 256'd5, 200000, cyc, got);
    check("n65537_finish", 64'(got), 64'd1);
    check("n65537_prime", 64'(prime), 64'd1);
    check("n65537_bound", 64'(cyc <= 5 * (256 + 16) * 130), 64'd1);

    do_run(m127, 256'd1, 40000, cyc, got);
    check("m127_finish", 64'(got), 64'd1);
    check("m127_prime", 64'(prime), 64'd1);
    check("m127_bound", 64'(cyc <= 1 * (256 + 1) * 130), 64'd1);

    // abort a long run with a reset pulse carrying a new candidate
    @(negedge clk);
    reset = 1'b1;
    start_number = m127;
    accuracy = 256'd5;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) @(negedge clk);
    check("abort_busy", 64'(finish), 64'd0);
    do_run(128'd15, 256'd5, 20000, cyc, got);
    check("abort_finish", 64'(got), 64'd1);
    check("abort_prime", 64'(prime), 64'd0);

    for (int run = 0; run < 20; run++) begin
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom_range(0, 65535));
      num = {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
      num[127:32] = '0;
      if (run % 2 == 0) num[0] = 1'b1;
      lim = 2 * (256 + 32) * 130;
      do_run(num, 256'd2, lim, cyc, got);
      check($sformatf("rand%0d_finish n=%0d", run, num), 64'(got), 64'd1);
      check($sformatf("rand%0d_prime n=%0d", run, num), 64'(prime),
            64'(mr_model(longint'(num[63:0]), 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
